// File: rtl/ray_pkg.sv
// Shared types and defaults for the ray-tracing pixel dispatch path.
// Holds the dispatcher FSM encoding and the active-core clamp.
package ray_pkg;

  localparam int DEF_X_W       = 11;
  localparam int DEF_Y_W       = 10;
  localparam int DEF_MAX_CORES = 4;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DONE
  } dispatch_state_t;

  // Requested core count is extra+1, clamped to the number of physical slots.
  function automatic int active_cores(input int extra, input int max_cores);
    return (extra >= max_cores - 1) ? max_cores : extra + 1;
  endfunction

endpackage

// File: rtl/pixel_dispatcher_if.sv
// Job offer bus between the pixel dispatcher and the ray-tracing cores.
// One-hot valid per core, shared coordinate bus, per-core ready.
interface pixel_dispatcher_if
  import ray_pkg::*;
#(
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int MAX_CORES = DEF_MAX_CORES
);

  logic [MAX_CORES-1:0] job_valid;
  logic [X_W-1:0]       job_x;
  logic [Y_W-1:0]       job_y;
  logic [MAX_CORES-1:0] core_ready;

  modport master (
    output job_valid,
    output job_x,
    output job_y,
    input  core_ready
  );

  modport slave (
    input  job_valid,
    input  job_x,
    input  job_y,
    output core_ready
  );

endinterface

// File: rtl/pixel_coord_counter.sv
// Raster-order x/y counter: x runs 0..width-1, then wraps and bumps y.
// last flags the final pixel of the frame at the current position.
module pixel_coord_counter #(
  parameter int X_W = 11,
  parameter int Y_W = 10
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           clear,
  input  logic           advance,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == width - X_W'(1));
  assign y_end = (y == height - Y_W'(1));
  assign last  = x_end && y_end;

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Hands out frame pixels in raster order to N cores round-robin, keeping
// at most N jobs outstanding, and pulses frame_done once all are written.
module pixel_dispatcher
  import ray_pkg::*;
#(
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int MAX_CORES = DEF_MAX_CORES
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic [X_W-1:0]     frame_width,
  input  logic [Y_W-1:0]     frame_height,
  input  logic [2:0]         no_of_extra_cores,
  input  logic               pixel_written,
  output logic               busy,
  output logic               frame_done,
  pixel_dispatcher_if.master jobs
);

  localparam int IDX_W = $clog2(MAX_CORES);
  localparam int OUT_W = $clog2(MAX_CORES) + 1;

  dispatch_state_t      state;
  dispatch_state_t      state_nxt;
  logic [OUT_W-1:0]     outstanding;
  logic [OUT_W-1:0]     out_nxt;
  logic [OUT_W-1:0]     n_cores;
  logic [IDX_W-1:0]     core_idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [MAX_CORES-1:0] valid_nxt;
  logic [X_W-1:0]       width_q;
  logic [Y_W-1:0]       height_q;
  logic                 accept;
  logic                 transfer;
  logic                 written;
  logic                 pix_last;

  assign accept   = (state == IDLE) && start;
  assign transfer = |(jobs.job_valid & jobs.core_ready);
  // A write with nothing in flight is stale and must not underflow the count.
  assign written  = pixel_written && (outstanding != '0);
  assign out_nxt  = outstanding + OUT_W'(transfer) - OUT_W'(written);
  assign busy     = (state == DISPATCH) || (state == DRAIN);

  pixel_coord_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_coord (
    .aclk    (aclk),
    .areset  (areset),
    .clear   (accept),
    .advance (transfer),
    .width   (width_q),
    .height  (height_q),
    .x       (jobs.job_x),
    .y       (jobs.job_y),
    .last    (pix_last)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = core_idx;
    valid_nxt = '0;
    if (transfer) begin
      idx_nxt = (core_idx == IDX_W'(n_cores - OUT_W'(1))) ? '0 : core_idx + IDX_W'(1);
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ((frame_width == '0) || (frame_height == '0)) ? DONE : DISPATCH;
          idx_nxt   = '0;
        end
      end
      DISPATCH: if (transfer && pix_last) state_nxt = DRAIN;
      DRAIN:    if (out_nxt == '0) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // n_cores is not yet loaded on the start cycle, but nothing is in flight then.
    if ((state_nxt == DISPATCH) && ((state == IDLE) || (out_nxt < n_cores))) begin
      valid_nxt = MAX_CORES'(1) << idx_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= IDLE;
      outstanding    <= '0;
      core_idx       <= '0;
      jobs.job_valid <= '0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      outstanding    <= out_nxt;
      core_idx       <= idx_nxt;
      jobs.job_valid <= valid_nxt;
      frame_done     <= (state == DONE);
    end
  end

  always_ff @(posedge aclk) begin
    if (accept) begin
      width_q  <= frame_width;
      height_q <= frame_height;
      n_cores  <= OUT_W'(active_cores(int'(no_of_extra_cores), MAX_CORES));
    end
  end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher: per-cycle vector table with
// hand-derived expectations plus a mid-frame reset sequence.
module tb_pixel_dispatcher;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [10:0] frame_width;
  logic [9:0]  frame_height;
  logic [2:0]  no_of_extra_cores;
  logic        pixel_written;
  logic        busy;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

  pixel_dispatcher_if #(.X_W(11), .Y_W(10), .MAX_CORES(4)) jobs_if ();

  pixel_dispatcher #(
    .X_W       (11),
    .Y_W       (10),
    .MAX_CORES (4)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .start             (start),
    .frame_width       (frame_width),
    .frame_height      (frame_height),
    .no_of_extra_cores (no_of_extra_cores),
    .pixel_written     (pixel_written),
    .busy              (busy),
    .frame_done        (frame_done),
    .jobs              (jobs_if)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    string    tag;
    bit       st;
    int       w;
    int       h;
    int       ex;
    bit [3:0] rdy;
    bit       pw;
    bit [3:0] ev;
    int       ex_x;
    int       ex_y;
    bit       eb;
    bit       ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string tag, input bit st, input int w, input int h,
                              input int ex, input bit [3:0] rdy, input bit pw,
                              input bit [3:0] ev, input int ex_x, input int ex_y,
                              input bit eb, input bit ed);
    vec_t r;
    r.tag = tag; r.st = st; r.w = w; r.h = h; r.ex = ex; r.rdy = rdy; r.pw = pw;
    r.ev = ev; r.ex_x = ex_x; r.ex_y = ex_y; r.eb = eb; r.ed = ed;
    tbl.push_back(r);
  endfunction

  // Coordinates only matter while a job is offered.
  function automatic logic [31:0] pack(input logic [3:0] v, input logic [10:0] x,
                                       input logic [9:0] y, input logic b, input logic d);
    return {5'd0, v, (v != 4'd0) ? x : 11'd0, (v != 4'd0) ? y : 10'd0, b, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    bit found;
    bit saw_done;

    areset = 1'b1; start = 1'b0; frame_width = '0; frame_height = '0;
    no_of_extra_cores = '0; pixel_written = 1'b0; jobs_if.core_ready = '0;
    step(); step();
    areset = 1'b0;
    check("reset_state", {5'd0, jobs_if.job_valid, jobs_if.job_x, jobs_if.job_y, busy, frame_done}, 32'd0);

    // 4x2 frame on four cores, each job written back one cycle after issue
    add("raster4x2", 1, 4, 2, 3, 4'hF, 0, 4'b0001, 0, 0, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 0, 4'b0010, 1, 0, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 1, 4'b0100, 2, 0, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 1, 4'b1000, 3, 0, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 1, 4'b0001, 0, 1, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 1, 4'b0010, 1, 1, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 1, 4'b0100, 2, 1, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 1, 4'b1000, 3, 1, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 1, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 1);
    add("raster4x2", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    // single core: one job in flight, next waits for a write-back
    add("stall1core", 1, 3, 1, 0, 4'hF, 0, 4'b0001, 0, 0, 1, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 1, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 1, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 1, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 1, 4'b0001, 1, 0, 1, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 1, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 1, 4'b0001, 2, 0, 1, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 1, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
    add("stall1core", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 1);
    add("stall1core", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    // core 1 not ready: its offer of (1,0) holds, core 0 is never skipped to
    add("hold", 1, 2, 2, 1, 4'b0001, 0, 4'b0001, 0, 0, 1, 0);
    add("hold", 0, 0, 0, 0, 4'b0001, 0, 4'b0010, 1, 0, 1, 0);
    add("hold", 0, 0, 0, 0, 4'b0001, 1, 4'b0010, 1, 0, 1, 0);
    add("hold", 0, 0, 0, 0, 4'b0001, 0, 4'b0010, 1, 0, 1, 0);
    add("hold", 0, 0, 0, 0, 4'b0001, 0, 4'b0010, 1, 0, 1, 0);
    add("hold", 0, 0, 0, 0, 4'b0001, 0, 4'b0010, 1, 0, 1, 0);
    add("hold", 0, 0, 0, 0, 4'b0001, 0, 4'b0010, 1, 0, 1, 0);
    add("hold", 0, 0, 0, 0, 4'hF,    0, 4'b0001, 0, 1, 1, 0);
    add("hold", 0, 0, 0, 0, 4'hF,    1, 4'b0010, 1, 1, 1, 0);
    add("hold", 0, 0, 0, 0, 4'hF,    1, 4'b0000, 0, 0, 1, 0);
    add("hold", 0, 0, 0, 0, 4'hF,    1, 4'b0000, 0, 0, 0, 0);
    add("hold", 0, 0, 0, 0, 4'hF,    0, 4'b0000, 0, 0, 0, 1);
    add("hold", 0, 0, 0, 0, 4'hF,    0, 4'b0000, 0, 0, 0, 0);
    // zero-width frame goes straight to completion
    add("zero", 1, 0, 5, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    add("zero", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 1);
    add("zero", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    // extra=6 clamps to 4 cores; start during DRAIN is ignored
    add("drain_start", 1, 5, 1, 6, 4'hF, 0, 4'b0001, 0, 0, 1, 0);
    add("drain_start", 0, 0, 0, 0, 4'hF, 0, 4'b0010, 1, 0, 1, 0);
    add("drain_start", 0, 0, 0, 0, 4'hF, 1, 4'b0100, 2, 0, 1, 0);
    add("drain_start", 0, 0, 0, 0, 4'hF, 1, 4'b1000, 3, 0, 1, 0);
    add("drain_start", 0, 0, 0, 0, 4'hF, 1, 4'b0001, 4, 0, 1, 0);
    add("drain_start", 0, 0, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 1, 0);
    add("drain_start", 1, 5, 1, 6, 4'hF, 0, 4'b0000, 0, 0, 1, 0);
    add("drain_start", 0, 0, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
    add("drain_start", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 1);
    add("drain_start", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    add("drain_start", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    // stray write-back while idle must not leave the in-flight count wrapped
    add("underflow", 0, 0, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
    add("underflow", 1, 2, 1, 0, 4'hF, 0, 4'b0001, 0, 0, 1, 0);
    add("underflow", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 1, 0);
    add("underflow", 0, 0, 0, 0, 4'hF, 1, 4'b0001, 1, 0, 1, 0);
    add("underflow", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 1, 0);
    add("underflow", 0, 0, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
    add("underflow", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 1);
    add("underflow", 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      start             = tbl[i].st;
      frame_width       = 11'(tbl[i].w);
      frame_height      = 10'(tbl[i].h);
      no_of_extra_cores = 3'(tbl[i].ex);
      jobs_if.core_ready = tbl[i].rdy;
      pixel_written     = tbl[i].pw;
      step();
      check($sformatf("%s[%0d]", tbl[i].tag, i),
            pack(jobs_if.job_valid, jobs_if.job_x, jobs_if.job_y, busy, frame_done),
            pack(tbl[i].ev, 11'(tbl[i].ex_x), 10'(tbl[i].ex_y), tbl[i].eb, tbl[i].ed));
    end

    // Reset in the middle of a frame, once pixel 3 is on offer
    start = 1'b1; frame_width = 11'd4; frame_height = 10'd2; no_of_extra_cores = 3'd3;
    jobs_if.core_ready = 4'hF; pixel_written = 1'b0;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (jobs_if.job_valid == 4'b1000 && jobs_if.job_x == 11'd3) found = 1'b1;
      else step();
    end
    check("reach_pixel3", {31'd0, found}, 32'd1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    check("reset_mid", {5'd0, jobs_if.job_valid, jobs_if.job_x, jobs_if.job_y, busy, frame_done}, 32'd0);
    saw_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      saw_done = saw_done | frame_done | busy;
    end
    check("no_done_after_reset", {31'd0, saw_done}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart", pack(jobs_if.job_valid, jobs_if.job_x, jobs_if.job_y, busy, frame_done),
          pack(4'b0001, 11'd0, 10'd0, 1'b1, 1'b0));
    step();
    check("restart_next", pack(jobs_if.job_valid, jobs_if.job_x, jobs_if.job_y, busy, frame_done),
          pack(4'b0010, 11'd1, 10'd0, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
